fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 13 +
 rtl/flex_counter.sv | 44 ++++
 rtl/fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared widths and FSM encoding for the frame-buffer arbiter.
package fb_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_WAIT = 2'd2,
    WR      = 2'd3
  } state_e;
endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover; rollover_flag is registered and is
// high during the cycle in which the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  // Next count: clear wins, otherwise wrap to zero after reaching rollover_val
  always_comb begin
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end else begin
      count_d = count_q;
    end
    flag_d = (count_d == rollover_val);
  end

  // Count and flag registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag = flag_q;
endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer SRAM arbiter: display reads (with one-deep pending slot) take
// priority over host writes; all SRAM-side signals are registered.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              underrun
);
  localparam logic [CNT_W-1:0] ROLL_VAL = CNT_W'(MEM_LATENCY);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              underrun_q, underrun_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic              disp_valid_q, disp_valid_d;
  logic              ready_q, ready_d;
  logic              roll_flag_s, wait_done_s, cnt_en_s;
  logic              rd_start_s, host_xfer_s;

  // ready_q keeps host_ready low during reset and one cycle after release
  assign host_ready  = ready_q & enable & ~disp_req;
  assign host_xfer_s = host_valid & host_ready;
  assign rd_start_s  = (state_q == IDLE) & enable & (disp_req | pending_q);
  assign cnt_en_s    = (state_q == RD) | (state_q == RD_WAIT);
  assign wait_done_s = (state_q == RD_WAIT) & roll_flag_s;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_wait_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (~cnt_en_s),
    .count_enable (cnt_en_s),
    .rollover_val (ROLL_VAL),
    .rollover_flag(roll_flag_s)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_start_s) begin
          state_d = RD;
        end else if (host_xfer_s) begin
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        if (wait_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and bookkeeping next values
  always_comb begin
    pending_d    = pending_q;
    pend_addr_d  = pend_addr_q;
    underrun_d   = underrun_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disp_data_d  = disp_data_q;
    mem_ren_d    = 1'b0;
    mem_wen_d    = 1'b0;
    disp_valid_d = 1'b0;
    if (!enable) begin
      pending_d  = 1'b0;
      underrun_d = 1'b0;
    end else if (rd_start_s) begin
      pending_d = 1'b0;
      mem_ren_d = 1'b1;
      if (pending_q) begin
        mem_addr_d = pend_addr_q;
        underrun_d = underrun_q | disp_req;
      end else begin
        mem_addr_d = disp_addr;
      end
    end else if (host_xfer_s) begin
      mem_wen_d   = 1'b1;
      mem_addr_d  = host_addr;
      mem_wdata_d = host_data;
    end else if (disp_req) begin
      // only reachable outside IDLE: park the request or drop it
      if (pending_q) begin
        underrun_d = 1'b1;
      end else begin
        pending_d   = 1'b1;
        pend_addr_d = disp_addr;
      end
    end else begin
      pending_d = pending_q;
    end
    if (wait_done_s) begin
      disp_data_d  = mem_rdata;
      disp_valid_d = 1'b1;
    end else begin
      disp_valid_d = 1'b0;
    end
    ready_d = (state_d == IDLE) & ~pending_d;
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q    <= 1'b0;
      pend_addr_q  <= '0;
      underrun_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_data_q  <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      pend_addr_q  <= pend_addr_d;
      underrun_q   <= underrun_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_data_q  <= disp_data_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      disp_valid_q <= disp_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign underrun   = underrun_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a time-based transaction model.
module tb_fb_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        n_rst, enable, disp_req, host_valid;
  logic [19:0] disp_addr, host_addr, mem_addr;
  logic [7:0]  host_data, mem_wdata, mem_rdata, disp_data;
  logic        disp_valid, host_ready, mem_ren, mem_wen, underrun;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.MEM_LATENCY(L)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .enable    (enable),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .host_valid(host_valid),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_ready(host_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .underrun  (underrun)
  );

  // Reference model: the arbiter is busy until cycle free_at; each accepted
  // operation schedules its future strobes into a small cycle-indexed ring.
  int          cyc = 0;
  int          free_at = 0;
  bit          pend_v, und_m;
  logic [19:0] pend_a;
  bit          s_ren[16], s_wen[16], s_val[16];
  logic [19:0] s_addr[16];
  logic [7:0]  s_wd[16];
  int          s_src[16];
  logic [7:0]  rd_hist[16];
  logic [19:0] m_addr;
  logic [7:0]  m_wd, m_dd;
  bit          rd_fix, m_accept, watch_on, seen_watch;
  logic [7:0]  rd_val;
  logic [19:0] watch_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at = 0; pend_v = 0; und_m = 0; pend_a = '0;
    m_addr = '0; m_wd = '0; m_dd = '0;
    for (int i = 0; i < 16; i++) begin
      s_ren[i] = 0; s_wen[i] = 0; s_val[i] = 0;
    end
  endtask

  // One clock cycle: drive rdata, check all outputs mid-cycle, advance model.
  task automatic tick();
    int          s;
    bit          idle, exp_rdy;
    logic [7:0]  rdv;
    logic [19:0] a;
    rdv = rd_fix ? rd_val : 8'((cyc * 53 + 7) & 255);
    mem_rdata = rdv;
    rd_hist[cyc % 16] = rdv;
    @(negedge clk);
    s = cyc % 16;
    if (!n_rst) model_reset();
    if (s_ren[s] || s_wen[s]) m_addr = s_addr[s];
    if (s_wen[s]) m_wd = s_wd[s];
    if (s_val[s]) m_dd = rd_hist[s_src[s] % 16];
    idle    = (cyc >= free_at);
    exp_rdy = n_rst && idle && enable && !disp_req && !pend_v;
    check("mem_ren",    mem_ren,    s_ren[s]);
    check("mem_wen",    mem_wen,    s_wen[s]);
    check("mem_addr",   mem_addr,   m_addr);
    check("mem_wdata",  mem_wdata,  m_wd);
    check("disp_valid", disp_valid, s_val[s]);
    check("disp_data",  disp_data,  m_dd);
    check("host_ready", host_ready, exp_rdy);
    check("underrun",   underrun,   und_m);
    if (watch_on && mem_addr === watch_a) seen_watch = 1;
    s_ren[s] = 0; s_wen[s] = 0; s_val[s] = 0;
    if (n_rst) begin
      if (!enable) begin
        pend_v = 0; und_m = 0;
      end
      if (idle && enable && (disp_req || pend_v)) begin
        a = pend_v ? pend_a : disp_addr;
        if (pend_v && disp_req) und_m = 1;
        pend_v = 0;
        s_ren[(cyc + 1) % 16] = 1; s_addr[(cyc + 1) % 16] = a;
        s_val[(cyc + 2 + L) % 16] = 1; s_src[(cyc + 2 + L) % 16] = cyc + 1 + L;
        free_at = cyc + 2 + L;
      end else if (exp_rdy && host_valid) begin
        s_wen[(cyc + 1) % 16] = 1; s_addr[(cyc + 1) % 16] = host_addr;
        s_wd[(cyc + 1) % 16] = host_data;
        free_at = cyc + 2;
        m_accept = 1;
      end else if (!idle && enable && disp_req) begin
        if (pend_v) und_m = 1;
        else begin
          pend_v = 1; pend_a = disp_addr;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drive(input logic en, input logic dr, input logic [19:0] da,
                       input logic hv, input logic [19:0] ha, input logic [7:0] hd);
    enable = en; disp_req = dr; disp_addr = da;
    host_valid = hv; host_addr = ha; host_data = hd;
    tick();
  endtask

  task automatic idle_n(input int n, input logic en);
    for (int i = 0; i < n; i++) drive(en, 1'b0, 20'h0, 1'b0, 20'h0, 8'h0);
  endtask

  initial begin
    n_rst = 1'b0; enable = 1'b0; disp_req = 1'b0; disp_addr = '0;
    host_valid = 1'b0; host_addr = '0; host_data = '0; mem_rdata = '0;
    rd_fix = 0; rd_val = '0; watch_on = 0; seen_watch = 0; watch_a = '0; m_accept = 0;
    model_reset();
    @(posedge clk); #1;

    // reset held with random inputs: every output must stay zero
    for (int i = 0; i < 4; i++)
      drive(1'($urandom), 1'($urandom), 20'($urandom), 1'($urandom), 20'($urandom), 8'($urandom));
    n_rst = 1'b1;
    idle_n(1, 1'b0);
    idle_n(2, 1'b1);
    check("ready_after_reset", host_ready, 1'b1);

    // display read with fixed SRAM data
    rd_fix = 1; rd_val = 8'hA5;
    drive(1'b1, 1'b1, 20'h12345, 1'b0, 20'h0, 8'h0);
    idle_n(5, 1'b1);
    check("read_data_a5", disp_data, 8'hA5);
    check("read_addr", mem_addr, 20'h12345);
    rd_fix = 0;

    // host write
    drive(1'b1, 1'b0, 20'h0, 1'b1, 20'h00010, 8'h3C);
    idle_n(2, 1'b1);
    check("write_addr", mem_addr, 20'h00010);
    check("write_data", mem_wdata, 8'h3C);

    // collision: display wins, host held until accepted
    m_accept = 0;
    drive(1'b1, 1'b1, 20'hABCDE, 1'b1, 20'h00777, 8'h5A);
    for (int i = 0; i < 8 && !m_accept; i++)
      drive(1'b1, 1'b0, 20'h0, 1'b1, 20'h00777, 8'h5A);
    idle_n(2, 1'b1);
    check("collision_wdata", mem_wdata, 8'h5A);
    check("collision_waddr", mem_addr, 20'h00777);

    // overflow: third back-to-back request dropped
    watch_a = 20'h0F0F0; seen_watch = 0; watch_on = 1;
    drive(1'b1, 1'b1, 20'h11111, 1'b0, 20'h0, 8'h0);
    drive(1'b1, 1'b1, 20'h22222, 1'b0, 20'h0, 8'h0);
    drive(1'b1, 1'b1, 20'h0F0F0, 1'b0, 20'h0, 8'h0);
    idle_n(12, 1'b1);
    watch_on = 0;
    check("overflow_underrun", underrun, 1'b1);
    check("overflow_addr_absent", seen_watch, 1'b0);
    check("overflow_second_addr", mem_addr, 20'h22222);

    // enable dropped during RD_WAIT: read finishes, then everything ignored
    drive(1'b1, 1'b1, 20'h33333, 1'b0, 20'h0, 8'h0);
    drive(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 8'h0);
    drive(1'b0, 1'b0, 20'h0, 1'b1, 20'h44444, 8'h77);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'(i % 2), 20'h55555, 1'b1, 20'h44444, 8'h77);
    check("disabled_underrun_clear", underrun, 1'b0);
    check("disabled_addr", mem_addr, 20'h33333);

    // reset in the middle of a read
    drive(1'b1, 1'b1, 20'h66666, 1'b0, 20'h0, 8'h0);
    drive(1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 8'h0);
    n_rst = 1'b0;
    idle_n(2, 1'b1);
    n_rst = 1'b1;
    idle_n(1, 1'b0);
    idle_n(6, 1'b1);
    check("reset_abort_data", disp_data, 8'h00);

    // random traffic
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(15, 0) != 0), 1'($urandom_range(4, 0) == 0), 20'($urandom),
            1'($urandom), 20'($urandom), 8'($urandom));
    idle_n(10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
